// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vend_pkg
//  Description : Shared types, coin map and coin valuation for the
//                multi-product vending controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package vend_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MANAGE = 3'd1,
    ST_SEL    = 3'd2,
    ST_QTY    = 3'd3,
    ST_MAKING = 3'd4,
    ST_READY  = 3'd5,
    ST_CHANGE = 3'd6
  } state_t;

  // Bit positions of each coin on Coin / ReturnCoin
  localparam int COIN_IDX_50   = 0;
  localparam int COIN_IDX_100  = 1;
  localparam int COIN_IDX_500  = 2;
  localparam int COIN_IDX_1000 = 3;

  // Coin values in 50-won units
  localparam logic [4:0] COIN_VAL_50   = 5'd1;
  localparam logic [4:0] COIN_VAL_100  = 5'd2;
  localparam logic [4:0] COIN_VAL_500  = 5'd10;
  localparam logic [4:0] COIN_VAL_1000 = 5'd20;

  // Value of a one-hot coin code; anything not exactly one-hot is worth 0
  function automatic logic [4:0] coin_value(input logic [3:0] coin);
    case (coin)
      4'b0001: return COIN_VAL_50;
      4'b0010: return COIN_VAL_100;
      4'b0100: return COIN_VAL_500;
      4'b1000: return COIN_VAL_1000;
      default: return 5'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vend_ctrl_multi_if.sv
`default_nettype none
// ============================================================================
//  Module      : vend_ctrl_multi_if
//  Description : Front-panel / brewer / delivery signal bundle for the
//                vending controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vend_ctrl_multi_if #(
  parameter int NUM_PROD = 4,
  parameter int PRICE_W  = 7,
  parameter int MAX_QTY  = 5,
  parameter int CREDIT_W = 8
);
  localparam int IDX_W = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1;

  logic                Manage;
  logic                Confirm;
  logic [IDX_W-1:0]    PriceIdx;
  logic [PRICE_W-1:0]  PriceVal;
  logic [3:0]          Coin;
  logic [NUM_PROD-1:0] Select;
  logic [MAX_QTY-1:0]  Cup;
  logic                Start;
  logic                Done;
  logic                TakeOut;
  logic                Return;
  logic [3:0]          ReturnCoin;
  logic                Making;
  logic                Coffee;
  logic                CoinReject;
  logic                Insufficient;
  logic [CREDIT_W-1:0] Sum;

  modport master (
    output Manage, Confirm, PriceIdx, PriceVal, Coin, Select, Cup,
           Start, Done, TakeOut, Return,
    input  ReturnCoin, Making, Coffee, CoinReject, Insufficient, Sum
  );

  modport slave (
    input  Manage, Confirm, PriceIdx, PriceVal, Coin, Select, Cup,
           Start, Done, TakeOut, Return,
    output ReturnCoin, Making, Coffee, CoinReject, Insufficient, Sum
  );

endinterface
`default_nettype wire

// File: rtl/vend_change_disp.sv
`default_nettype none
// ============================================================================
//  Module      : vend_change_disp
//  Description : Greedy change selector - picks the largest coin not
//                exceeding the remaining credit.
//  Revision    : 1.0 - initial release
// ============================================================================
module vend_change_disp
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] sum,
  output logic [3:0]          coin,
  output logic [CREDIT_W-1:0] value
);

  // Largest coin that fits; zero credit yields no coin
  always_comb begin
    coin = '0;
    if (sum >= CREDIT_W'(COIN_VAL_1000))     coin[COIN_IDX_1000] = 1'b1;
    else if (sum >= CREDIT_W'(COIN_VAL_500)) coin[COIN_IDX_500]  = 1'b1;
    else if (sum >= CREDIT_W'(COIN_VAL_100)) coin[COIN_IDX_100]  = 1'b1;
    else if (sum >= CREDIT_W'(COIN_VAL_50))  coin[COIN_IDX_50]   = 1'b1;
    value = CREDIT_W'(coin_value(coin));
  end

endmodule
`default_nettype wire

// File: rtl/vend_ctrl_multi.sv
`default_nettype none
// ============================================================================
//  Module      : vend_ctrl_multi
//  Description : Multi-product vending controller with run-time prices,
//                quantity selection, saturating credit and greedy change.
//  Revision    : 1.0 - initial release
// ============================================================================
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int NUM_PROD = 4,
  parameter int PRICE_W  = 7,
  parameter int MAX_QTY  = 5,
  parameter int CREDIT_W = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  vend_ctrl_multi_if.slave  bus
);

  localparam int IDX_W   = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1;
  localparam int QTY_W   = $clog2(MAX_QTY + 1);
  localparam int COST_W  = PRICE_W + 3;
  localparam int SUMX_W  = CREDIT_W + 1;
  localparam logic [SUMX_W-1:0] SUM_MAX = SUMX_W'({CREDIT_W{1'b1}});

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] sum_q, sum_d;
  logic [PRICE_W-1:0]  price_q [NUM_PROD];
  logic [PRICE_W-1:0]  price_d [NUM_PROD];
  logic [IDX_W-1:0]    prod_q, prod_d;
  logic [QTY_W-1:0]    qty_q, qty_d;
  logic [COST_W-1:0]   cost_q, cost_d;
  logic [3:0]          return_coin_q, return_coin_d;
  logic                making_q, making_d;
  logic                coffee_q, coffee_d;
  logic                coin_reject_q, coin_reject_d;
  logic                insufficient_q, insufficient_d;

  logic [IDX_W-1:0]    w_sel_idx;
  logic [QTY_W-1:0]    w_cup_qty;
  logic                w_sel_ok, w_cup_ok;
  logic [SUMX_W-1:0]   w_sum_ext;
  logic                w_coin_ok, w_coin_bad;
  logic [CREDIT_W-1:0] w_sum_in;
  logic [3:0]          w_disp_coin;
  logic [CREDIT_W-1:0] w_disp_val;

  vend_change_disp #(.CREDIT_W(CREDIT_W)) u_disp (
    .sum   (sum_q),
    .coin  (w_disp_coin),
    .value (w_disp_val)
  );

  // Decode one-hot Select / Cup; a Select only counts for a priced product
  always_comb begin
    w_sel_idx = '0;
    w_cup_qty = '0;
    for (int i = 0; i < NUM_PROD; i++) if (bus.Select[i]) w_sel_idx = IDX_W'(i);
    for (int k = 0; k < MAX_QTY; k++)  if (bus.Cup[k])    w_cup_qty = QTY_W'(k + 1);
    w_sel_ok = $onehot(bus.Select) && (price_q[w_sel_idx] != '0);
    w_cup_ok = $onehot(bus.Cup);
  end

  // Coin acceptance: right state, exactly one coin, no credit overflow
  always_comb begin
    w_sum_ext  = SUMX_W'(sum_q) + SUMX_W'(coin_value(bus.Coin));
    w_coin_ok  = ((state_q == ST_IDLE) || (state_q == ST_SEL) || (state_q == ST_QTY))
                 && $onehot(bus.Coin) && (w_sum_ext <= SUM_MAX);
    w_coin_bad = (bus.Coin != 4'b0000) && !w_coin_ok;
    w_sum_in   = w_coin_ok ? w_sum_ext[CREDIT_W-1:0] : sum_q;
  end

  // Next-state and next-output computation; Return > Start > Cup > Select
  always_comb begin
    state_d        = state_q;
    sum_d          = w_sum_in;
    price_d        = price_q;
    prod_d         = prod_q;
    qty_d          = qty_q;
    return_coin_d  = 4'b0000;
    coin_reject_d  = w_coin_bad;
    insufficient_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.Return && (sum_q != '0)) begin
          state_d = ST_CHANGE;
        end else if (bus.Manage && (sum_q == '0) && !w_coin_ok) begin
          state_d = ST_MANAGE;
        end else if (w_sel_ok) begin
          prod_d  = w_sel_idx;
          state_d = ST_SEL;
        end
      end
      ST_MANAGE: begin
        if (bus.Confirm && (int'(bus.PriceIdx) < NUM_PROD)) price_d[bus.PriceIdx] = bus.PriceVal;
        if (bus.Manage) state_d = ST_IDLE;
      end
      ST_SEL: begin
        if (bus.Return && (sum_q != '0)) begin
          state_d = ST_CHANGE;
        end else if (w_cup_ok) begin
          qty_d   = w_cup_qty;
          state_d = ST_QTY;
        end else if (w_sel_ok) begin
          prod_d = w_sel_idx;
        end
      end
      ST_QTY: begin
        if (bus.Return && (sum_q != '0)) begin
          state_d = ST_CHANGE;
        end else if (bus.Start) begin
          // A coin arriving with Start is already folded into w_sum_in
          if (32'(w_sum_in) >= 32'(cost_q)) begin
            sum_d   = w_sum_in - CREDIT_W'(cost_q);
            state_d = ST_MAKING;
          end else begin
            insufficient_d = 1'b1;
          end
        end else if (w_cup_ok) begin
          qty_d = w_cup_qty;
        end else if (w_sel_ok) begin
          prod_d = w_sel_idx;
        end
      end
      ST_MAKING: if (bus.Done)    state_d = ST_READY;
      ST_READY:  if (bus.TakeOut) state_d = ST_IDLE;
      ST_CHANGE: begin
        if (sum_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          return_coin_d = w_disp_coin;
          sum_d         = sum_q - w_disp_val;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Selection is forgotten whenever the controller heads back to idle or change
    if ((state_d == ST_IDLE) || (state_d == ST_CHANGE)) begin
      prod_d = '0;
      qty_d  = '0;
    end

    cost_d   = COST_W'(price_q[prod_d]) * COST_W'(qty_d);
    making_d = (state_d == ST_MAKING);
    coffee_d = (state_d == ST_READY);
  end

  // State and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q        <= ST_IDLE;
      sum_q          <= '0;
      price_q        <= '{default: '0};
      prod_q         <= '0;
      qty_q          <= '0;
      cost_q         <= '0;
      return_coin_q  <= 4'b0000;
      making_q       <= 1'b0;
      coffee_q       <= 1'b0;
      coin_reject_q  <= 1'b0;
      insufficient_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sum_q          <= sum_d;
      price_q        <= price_d;
      prod_q         <= prod_d;
      qty_q          <= qty_d;
      cost_q         <= cost_d;
      return_coin_q  <= return_coin_d;
      making_q       <= making_d;
      coffee_q       <= coffee_d;
      coin_reject_q  <= coin_reject_d;
      insufficient_q <= insufficient_d;
    end
  end

  assign bus.ReturnCoin   = return_coin_q;
  assign bus.Making       = making_q;
  assign bus.Coffee       = coffee_q;
  assign bus.CoinReject   = coin_reject_q;
  assign bus.Insufficient = insufficient_q;
  assign bus.Sum          = sum_q;

endmodule
`default_nettype wire

// File: doc/vend_ctrl_multi.md
Name: vend_ctrl_multi

Overview:
- Parametrised successor to the coffee vending controller.
- Supports NUM_PROD products with prices programmed at run time, cup quantity 1..MAX_QTY, and a saturating credit register.
- Returns change one coin per cycle using a greedy coin dispenser.
- Sits between the coin/button front panel and the brewer interface: Start/Making/Done go to the brewer, Coffee/TakeOut to the delivery slot.

Parameters:
- NUM_PROD, 4, number of selectable products.
- PRICE_W, 7, price width in 50-won units.
- MAX_QTY, 5, maximum cups per purchase; Cup is one-hot of this width.
- CREDIT_W, 8, credit (Sum) width in 50-won units.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- Manage  in  1  pulse; toggles price-programming mode.
- Confirm  in  1  pulse; in MANAGE, writes PriceVal to price[PriceIdx].
- PriceIdx  in  $clog2(NUM_PROD)  product index to program.
- PriceVal  in  PRICE_W  new price, in 50-won units.
- Coin  in  4  one-cycle pulses; bit0=50, bit1=100, bit2=500, bit3=1000.
- Select  in  NUM_PROD  one-hot product choice.
- Cup  in  MAX_QTY  one-hot quantity; bit k means k+1 cups.
- Start  in  1  pulse; request brew.
- Done  in  1  pulse from brewer; brew finished.
- TakeOut  in  1  pulse; customer has removed the cup(s).
- Return  in  1  pulse; request change.
- ReturnCoin  out  4  one-hot coin-eject pulse, same bit map as Coin.
- Making  out  1  high throughout MAKING.
- Coffee  out  1  high throughout READY.
- CoinReject  out  1  1-cycle pulse; coin refused.
- Insufficient  out  1  1-cycle pulse; Start refused for lack of credit.
- Sum  out  CREDIT_W  current credit, registered.

Behaviour:
- Reset (asynchronous, RST_N=0):
  - state=IDLE; Sum=0; all prices=0; latched product and quantity cleared.
  - All outputs 0.
  - Reset mid-operation (MAKING, CHANGE, …) discards credit with no change paid.
- Coin values in units: 1, 2, 10, 20.
  - A coin is accepted only in IDLE, SEL or QTY, with exactly one Coin bit set and Sum+value ≤ 2^CREDIT_W−1.
  - Otherwise CoinReject pulses the next cycle and Sum is unchanged.
  - An accepted coin updates Sum on the next edge.
- States:
  - IDLE:
    - Manage with Sum==0 → MANAGE; Manage with Sum≠0 is ignored.
    - Select with price≠0 latches the product → SEL.
  - MANAGE: Confirm writes the price; Manage → IDLE. No other input has effect.
  - SEL: Select re-latches the product; Cup latches qty → QTY.
  - QTY:
    - Cost = price×qty, registered one cycle after Cup, width PRICE_W+3.
    - Start with Sum ≥ cost: Sum −= cost → MAKING.
    - Start with Sum < cost: Insufficient pulse, state holds.
    - Select or Cup in QTY re-latches the product/quantity.
  - MAKING: Making=1; Done → READY.
  - READY: Coffee=1; TakeOut → IDLE. Remaining credit is kept.
  - CHANGE:
    - Each cycle, eject the largest coin ≤ Sum, pulse its ReturnCoin bit for 1 cycle, and subtract its value.
    - When Sum==0, go to IDLE; no pulse in the exit cycle.
- Return:
  - Return in IDLE/SEL/QTY with Sum>0 clears the selection → CHANGE.
  - Return with Sum==0 is ignored.
  - Return in any other state is ignored.
- Same-cycle priority: Return > Start > Cup > Select.
- A coin accepted in the same cycle as Return is included in the change: CHANGE starts the next cycle with the updated Sum.
- A coin in the same cycle as Start is added before the cost comparison is made (next cycle).
- A price change cannot affect an in-flight purchase: MANAGE is only reachable with Sum==0 from IDLE.
- An illegal one-hot on Select or Cup (zero or multiple bits) is ignored.

Decomposition:
- Package vend_pkg:
  - state enum (IDLE, MANAGE, SEL, QTY, MAKING, READY, CHANGE);
  - coin index localparams and coin unit values (1, 2, 10, 20);
  - function coin_value(one-hot).
- Sub-module vend_change_disp: combinational greedy selector.
  - Input: Sum.
  - Outputs: one-hot coin and its value.
  - Instantiated once, used in CHANGE.

Test Plan:
1. Manage; PriceIdx=0, PriceVal=8, Confirm; Manage → IDLE. Price[0]=8 is observable via item 2 (Start succeeds at Sum=16).
2. 3×Coin[1] → Sum=6; Select=0001, Cup=00001, Start → Insufficient pulse, Sum=6. Coin[2] → Sum=16; Start → Sum=8, Making=1; Done → Coffee=1; TakeOut → IDLE, Sum=8.
3. Sum=37 then Return → ReturnCoin pulses 1000, 500, 100, 100, 100, 50 on 6 consecutive cycles; Sum=0; IDLE.
4. CREDIT_W=8, Sum=250, Coin[3] → CoinReject pulse, Sum=250; Coin with two bits set → rejected.
5. Price 8, Cup=00100 (qty 3), Sum=24, Start → Sum=0. Coin[0] during MAKING → CoinReject, Sum stays 0.
6. RST_N low mid-CHANGE (Sum=12) → ReturnCoin=0, Sum=0, IDLE immediately. Coin[0] and Return in the same cycle at Sum=2 → pulses 100, 50.
